decode_stage_p: RTL
===================

// Module: decode_stage_p
// PURPOSE
//  Parametrised RV32-subset instruction-decode stage: XLEN-wide register file, combinational control decode,
//  sign-correct immediate generation, data-hazard interlock and branch-shadow FSM, feeding a valid-tagged
//  ID/EX pipeline register. Sits between the IF/ID register and the execute stage of the 5-stage core.
// PARAMETERS
//  XLEN       32  datapath width (32 or 64); immediates sign-extend to XLEN
//  NREG       32  architectural registers (16 or 32); x0 hardwired to zero
//  BR_SHADOW  2   fetch-freeze cycles after a branch issues (1..7)
// PORTS
//  clock           in   1      rising-edge clock
//  reset           in   1      synchronous, active-high
//  instruction     in   32     instruction from IF/ID
//  pc              in   XLEN   PC of instruction
//  if_valid        in   1      IF/ID holds a real instruction
//  wb_we / wb_rd / wb_data  in  1/5/XLEN  register write port from WB
//  ex_rd, ex_wr    in   5,1    destination + write flag of instruction in EX
//  mem_rd, mem_wr  in   5,1    destination + write flag of instruction in MEM
//  pc_load, if_id_load  out 1  fetch advance enables (combinational)
//  illegal         out  1      sticky: opcode unknown or register index >= NREG
//  id_ex_valid     out  1      ID/EX holds a real instruction
//  mem_re_out, mem_we_out, reg_file_write_out, branch_out  out 1  registered controls
//  alu_op_out, select_mux_1_out, select_mux_2_out, select_mux_4_out  out 2  registered controls
//  reg_a_out, reg_b_out, immediate_out, pc_out  out XLEN  registered operands
//  rd_out out 5; funct_out out 10 = {instr[31:25], instr[14:12]}
// BEHAVIOUR
//  - Reset: every output register, the register file, illegal and FSM (IDLE) clear to 0; pc_load = if_id_load = 0 while reset high.
//  - Decode (comb): R 0110011 {re0,we0,wr1,alu10,m1=0,m2=1,m4=0}; LOAD 0000011 {1,0,1,01,1,0,0};
//    STORE 0100011 {0,1,0,00,1,0,1}; BRANCH 1100011 {0,0,0,00,0,0,0,br=1}; others: illegal, issue as bubble.
//  - Immediate: I = sext(i[31:20]); S = sext({i[31:25],i[11:7]}); B = sext({i[31],i[7],i[30:25],i[11:8],1'b0}); else 0.
//  - Sources: R/STORE/BRANCH read rs1,rs2; LOAD reads rs1 only. Index >= NREG -> illegal (sticky until reset), bubble.
//  - Hazard: used source s != 0 and ((s==ex_rd & ex_wr) | (s==mem_rd & mem_wr) | (s==wb_rd & wb_we, see CONFIGURATION)).
//  - Issue = if_valid & !hazard & state==IDLE & legal. pc_load = if_id_load = !hazard & state==IDLE.
//  - ID/EX latches every cycle (1-cycle latency): on issue, decoded fields + id_ex_valid=1; otherwise bubble:
//    id_ex_valid, all controls and all data fields = 0.
//  - FSM IDLE -> SHADOW when a branch issues; cnt loads BR_SHADOW. In SHADOW pc_load=if_id_load=0, bubbles issued,
//    cnt decrements; cnt==1 -> IDLE next edge. Hazard and branch in same cycle: hazard wins, branch not yet issued.
//  - Register file: write on clock edge when wb_we & wb_rd!=0 & wb_rd<NREG; writes to x0 ignored; reads combinational.
//  - Reset mid-shadow or mid-stall: FSM to IDLE, ID/EX bubble, next cycle fetch resumes.
// CONFIGURATION
//  DECODE_WB_BYPASS_EN defined: read returns wb_data when wb_we & wb_rd==source & source!=0; WB match never stalls.
//  Not defined: read returns stored value; a WB match is a hazard (1-cycle stall until write lands).
// TESTING
//  1 reset held 2 cycles -> all outputs 0, pc_load=if_id_load=0, illegal=0.
//  2 WB write x1=5, x2=7; issue add x3,x1,x2 (0x002081B3) -> next cycle id_ex_valid=1, reg_a=5, reg_b=7, rd_out=3, alu_op=10, reg_file_write_out=1.
//  3 ex_rd=1, ex_wr=1 with 0x002081B3 -> pc_load=if_id_load=0, id_ex_valid=0 next; clearing ex_wr -> issues next cycle.
//  4 beq x0,x0,-4 (0xFE000EE3), BR_SHADOW=2 -> immediate_out=sext(-4)=0xFFFFFFFC, branch_out=1; next 2 cycles bubble, fetch frozen; 3rd cycle fetch resumes.
//  5 wb_we=1, wb_rd=1, wb_data=0xDEAD same cycle as 0x002081B3 -> with macro reg_a_out=0xDEAD no stall; without, one stall then reg_a_out=0xDEAD.
//  6 opcode 0x7F, then NREG=16 with rs1=17 -> bubble, illegal=1 and stays 1 until reset.

Source files
------------

// File: rtl/decode_stage_p.sv
// decode_stage_p: RV32-subset decode stage (regfile, control decode, immediates, hazard interlock, branch shadow, ID/EX register).
// Define DECODE_WB_BYPASS_EN to forward the WB write port into operand reads instead of stalling on it.
module decode_stage_p #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int BR_SHADOW = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic            if_valid,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_wr,
    input  logic [4:0]      mem_rd,
    input  logic            mem_wr,
    output logic            pc_load,
    output logic            if_id_load,
    output logic            illegal,
    output logic            id_ex_valid,
    output logic            mem_re_out,
    output logic            mem_we_out,
    output logic            reg_file_write_out,
    output logic            branch_out,
    output logic [1:0]      alu_op_out,
    output logic [1:0]      select_mux_1_out,
    output logic [1:0]      select_mux_2_out,
    output logic [1:0]      select_mux_4_out,
    output logic [XLEN-1:0] reg_a_out,
    output logic [XLEN-1:0] reg_b_out,
    output logic [XLEN-1:0] immediate_out,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd_out,
    output logic [9:0]      funct_out
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SHADOW = 1'b1;
`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam logic [5:0] NR = 6'(NREG);
    localparam logic [2:0] SH = 3'(BR_SHADOW);

    // Sized for the full 5-bit index space; entries at or above NREG are never written and read as zero.
    logic [XLEN-1:0] rf [32];
    logic [0:0]      state;
    logic [2:0]      cnt;
    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            is_r, is_ld, is_st, is_br, use1, use2, bad, legal;
    logic            hz1, hz2, hazard, idle, issue;
    logic [XLEN-1:0] a, b, imm;

    assign opcode = instruction[6:0];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign rd     = instruction[11:7];
    assign is_r   = opcode == 7'b0110011;
    assign is_ld  = opcode == 7'b0000011;
    assign is_st  = opcode == 7'b0100011;
    assign is_br  = opcode == 7'b1100011;
    assign use1   = is_r || is_ld || is_st || is_br;
    assign use2   = is_r || is_st || is_br;
    assign bad    = (use1 && {1'b0, rs1} >= NR) || (use2 && {1'b0, rs2} >= NR)
                 || ((is_r || is_ld) && {1'b0, rd} >= NR);
    assign legal  = use1 && !bad;

    assign hz1 = use1 && rs1 != 5'd0 && ((rs1 == ex_rd && ex_wr) || (rs1 == mem_rd && mem_wr)
              || (!BYPASS && rs1 == wb_rd && wb_we));
    assign hz2 = use2 && rs2 != 5'd0 && ((rs2 == ex_rd && ex_wr) || (rs2 == mem_rd && mem_wr)
              || (!BYPASS && rs2 == wb_rd && wb_we));
    assign hazard = hz1 || hz2;
    assign idle   = state == IDLE;
    assign issue  = if_valid && !hazard && idle && legal;

    assign pc_load    = !reset && !hazard && idle;
    assign if_id_load = pc_load;

    assign a = (BYPASS && wb_we && wb_rd == rs1 && rs1 != 5'd0) ? wb_data : rf[rs1];
    assign b = (BYPASS && wb_we && wb_rd == rs2 && rs2 != 5'd0) ? wb_data : rf[rs2];

    assign imm = is_ld ? {{(XLEN-12){instruction[31]}}, instruction[31:20]}
               : is_st ? {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]}
               : is_br ? {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0}
               : '0;

    always_ff @(posedge clock) begin
        if (reset || !issue) begin
            id_ex_valid        <= 1'b0;
            mem_re_out         <= 1'b0;
            mem_we_out         <= 1'b0;
            reg_file_write_out <= 1'b0;
            branch_out         <= 1'b0;
            alu_op_out         <= 2'b00;
            select_mux_1_out   <= 2'b00;
            select_mux_2_out   <= 2'b00;
            select_mux_4_out   <= 2'b00;
            reg_a_out          <= '0;
            reg_b_out          <= '0;
            immediate_out      <= '0;
            pc_out             <= '0;
            rd_out             <= 5'd0;
            funct_out          <= 10'd0;
        end else begin
            id_ex_valid        <= 1'b1;
            mem_re_out         <= is_ld;
            mem_we_out         <= is_st;
            reg_file_write_out <= is_r || is_ld;
            branch_out         <= is_br;
            alu_op_out         <= is_r ? 2'b10 : is_ld ? 2'b01 : 2'b00;
            select_mux_1_out   <= {1'b0, is_ld || is_st};
            select_mux_2_out   <= {1'b0, is_r};
            select_mux_4_out   <= {1'b0, is_st};
            reg_a_out          <= a;
            reg_b_out          <= use2 ? b : '0;
            immediate_out      <= imm;
            pc_out             <= pc;
            rd_out             <= rd;
            funct_out          <= {instruction[31:25], instruction[14:12]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            illegal <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (issue && is_br) begin
                state <= SHADOW;
                cnt   <= SH;
            end else if (!idle) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1) state <= IDLE;
            end
            if (if_valid && idle && !legal) illegal <= 1'b1;
            if (wb_we && wb_rd != 5'd0 && {1'b0, wb_rd} < NR) rf[wb_rd] <= wb_data;
        end
    end
endmodule
